lcd_nibble_transmitter: RTL

//   Physical-layer stage directly downstream of the LCD configure FSM.

---
 rtl/lcd_nibble_transmitter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/lcd_nibble_transmitter.sv
// HD44780 4-bit physical layer: power-on init sequence, then one {RS,RW,D} word
// per next_instruction pulse, sent as two E-strobed nibbles with execution wait.
module lcd_nibble_transmitter #(
  parameter int unsigned T_SETUP    = 2,
  parameter int unsigned T_E_HIGH   = 12,
  parameter int unsigned T_HOLD     = 1,
  parameter int unsigned T_NIB_GAP  = 50,
  parameter int unsigned T_CMD_WAIT = 2000,
  parameter int unsigned T_PWR      = 750000,
  parameter int unsigned T_INIT1    = 205000,
  parameter int unsigned T_INIT2    = 5000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       next_instruction,
  input  logic [9:0] db,
  output logic       done,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d
);

  typedef enum logic [3:0] {
    PWR_WAIT, INIT_SETUP, INIT_E, INIT_HOLD, INIT_WAIT,
    IDLE, LATCH, SETUP_H, E_H, HOLD_H, GAP, SETUP_L, E_L, HOLD_L, CMD_WAIT
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, wait_lim;
  logic [1:0]       step, step_next;
  logic             rs_q, rs_next;
  logic [7:0]       data_q, data_next;
  logic             done_n, init_done_n, busy_n, lcd_e_n, lcd_rs_n, illegal;
  logic [3:0]       lcd_d_n;

  // RW bit of the word is meaningless here: the bus is write-only.
  logic db_rw_unused;
  assign db_rw_unused = db[8];
  assign lcd_rw = 1'b0;

  function automatic logic [CNT_W-1:0] lim(input int unsigned t);
    return CNT_W'(t - 1);
  endfunction

  always_comb begin
    state_next  = state;
    step_next   = step;
    rs_next     = rs_q;
    data_next   = data_q;
    done_n      = 1'b0;
    init_done_n = init_done;
    illegal     = 1'b0;
    case (step)
      2'd0:    wait_lim = lim(T_INIT1);
      2'd1:    wait_lim = lim(T_INIT2);
      default: wait_lim = lim(T_CMD_WAIT);
    endcase

    case (state)
      PWR_WAIT:   if (cnt == lim(T_PWR))    state_next = INIT_SETUP;
      INIT_SETUP: if (cnt == lim(T_SETUP))  state_next = INIT_E;
      INIT_E:     if (cnt == lim(T_E_HIGH)) state_next = INIT_HOLD;
      INIT_HOLD:  if (cnt == lim(T_HOLD))   state_next = INIT_WAIT;
      INIT_WAIT: begin
        if (cnt == wait_lim) begin
          if (step == 2'd3) begin
            state_next  = IDLE;
            init_done_n = 1'b1;
          end else begin
            step_next  = step + 2'd1;
            state_next = INIT_SETUP;
          end
        end
      end
      IDLE:       if (next_instruction) state_next = LATCH;
      LATCH: begin
        rs_next    = db[9];
        data_next  = db[7:0];
        state_next = SETUP_H;
      end
      SETUP_H:    if (cnt == lim(T_SETUP))   state_next = E_H;
      E_H:        if (cnt == lim(T_E_HIGH))  state_next = HOLD_H;
      HOLD_H:     if (cnt == lim(T_HOLD))    state_next = GAP;
      GAP:        if (cnt == lim(T_NIB_GAP)) state_next = SETUP_L;
      SETUP_L:    if (cnt == lim(T_SETUP))   state_next = E_L;
      E_L:        if (cnt == lim(T_E_HIGH))  state_next = HOLD_L;
      HOLD_L:     if (cnt == lim(T_HOLD))    state_next = CMD_WAIT;
      CMD_WAIT: begin
        if (cnt == lim(T_CMD_WAIT)) begin
          state_next = IDLE;
          done_n     = 1'b1;
        end
      end
      default: begin
        state_next = PWR_WAIT;
        step_next  = 2'd0;
        illegal    = 1'b1;
      end
    endcase

    // Outputs are registered from the upcoming state, so bus values only move
    // on entry to a SETUP state and E can never overlap a bus change.
    lcd_e_n  = (state_next == INIT_E) || (state_next == E_H) || (state_next == E_L);
    lcd_rs_n = lcd_rs;
    lcd_d_n  = lcd_d;
    busy_n   = (state_next != IDLE);
    if (state_next == INIT_SETUP && state != INIT_SETUP) begin
      lcd_rs_n = 1'b0;
      lcd_d_n  = (step_next == 2'd3) ? 4'h2 : 4'h3;
    end
    if (state_next == SETUP_H && state != SETUP_H) begin
      lcd_rs_n = rs_next;
      lcd_d_n  = data_next[7:4];
    end
    if (state_next == SETUP_L && state != SETUP_L) begin
      lcd_d_n = data_q[3:0];
    end
    if (illegal) begin
      lcd_e_n     = 1'b0;
      lcd_rs_n    = 1'b0;
      lcd_d_n     = '0;
      busy_n      = 1'b0;
      init_done_n = 1'b0;
      done_n      = 1'b0;
    end

    cnt_next = (state_next != state || state_next == IDLE) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PWR_WAIT;
      cnt       <= '0;
      step      <= '0;
      rs_q      <= 1'b0;
      data_q    <= '0;
      done      <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_d     <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      step      <= step_next;
      rs_q      <= rs_next;
      data_q    <= data_next;
      done      <= done_n;
      init_done <= init_done_n;
      busy      <= busy_n;
      lcd_e     <= lcd_e_n;
      lcd_rs    <= lcd_rs_n;
      lcd_d     <= lcd_d_n;
    end
  end

endmodule
